rom_fetch_arbiter: RTL and testbench
====================================

Name: rom_fetch_arbiter

Overview:
- Shares the single instruction ROM between two requesters over the ROM's request/response handshake.
  - Master 0: CPU fetch port.
  - Master 1: debug/loader read port.
- Sits between the cpu and rom instances in the top level. It drives the ROM's ready/addr inputs and routes dout/en_out back to the requester that owns the transaction.
- Round-robin arbitration, one outstanding transaction, response timeout with error report.

Parameters:
- ADDR_W, 16, width of the ROM address bus and of both master address ports.
- DATA_W, 16, width of the instruction word.
- TIMEOUT, 255, maximum cycles in WAIT before the transaction is aborted (legal range 1..65535).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high with m0_addr stable until m0_gnt.
- m0_addr  in  ADDR_W  master 0 read address.
- m0_gnt  out  1  one-cycle pulse: request accepted and issued to ROM.
- m0_rdata  out  DATA_W  read data; valid when m0_rvalid is high, held until next m0 response.
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid.
- m0_err  out  1  one-cycle pulse: master 0 transaction timed out.
- m1_req, m1_addr, m1_gnt, m1_rdata, m1_rvalid, m1_err: same as master 0, for master 1.
- rom_ready  out  1  to ROM ready; one-cycle request strobe.
- rom_addr  out  ADDR_W  to ROM addr; held from ISSUE through end of WAIT.
- rom_dout  in  DATA_W  ROM data out.
- rom_en_out  in  1  ROM data-valid strobe.

Behaviour:
- Reset (rst sampled high):
  - state=IDLE, last_grant=1 (so m0 wins the first tie), owner=0, timeout counter=0.
  - All outputs 0, including rom_addr and both rdata.
  - Reset mid-transaction abandons it silently: no rvalid and no err; a later rom_en_out is ignored.
- FSM states:
  - IDLE
    - If neither req is high, stay.
    - If exactly one req is high, select it.
    - If both are high, select the master not equal to last_grant.
    - On selection: latch owner and that master's addr into rom_addr, go to ISSUE.
  - ISSUE (exactly 1 cycle)
    - rom_ready=1; m<owner>_gnt=1; last_grant<=owner; counter cleared; go to WAIT.
  - WAIT
    - On rom_en_out=1: capture rom_dout into m<owner>_rdata and pulse m<owner>_rvalid on the next cycle (registered); go to IDLE.
    - Otherwise increment the counter. When counter==TIMEOUT-1 with no en_out: pulse m<owner>_err next cycle, leave rdata unchanged, go to IDLE.
    - If en_out arrives on the same cycle the counter hits TIMEOUT-1, data wins: rvalid, no err.
- rom_en_out in IDLE or ISSUE is a stray strobe: ignored, and no output changes.
- The non-owner's gnt, rvalid and err stay 0 throughout a transaction. Its req may rise or fall freely and is only sampled in IDLE.
- Latency:
  - req high in IDLE at cycle N → gnt and rom_ready at N+1.
  - ROM en_out at cycle K → rvalid at K+1.
  - With a 1-cycle ROM (en_out at N+2), rvalid is at N+3.
  - Next arbitration occurs in the cycle rvalid is high, so back-to-back requests issue every 3 cycles.
- A master that keeps req high after gnt is treated as issuing a new request at the next IDLE, at the address present then.
- Fairness: with both reqs continuously high, grants alternate m0, m1, m0, … Neither master waits more than one transaction.
- Counter width: clog2(TIMEOUT+1); it does not wrap.

Test Plan:
- Single m0 read: rst 2 cycles; m0_req=1, m0_addr=0x0004 at cycle 0; ROM model returns 0x1234 with en_out one cycle after ready → m0_gnt and rom_ready at cycle 1 with rom_addr=0x0004, m0_rvalid at cycle 3 with m0_rdata=0x1234; m1 outputs all 0.
- Contention: m0_req and m1_req high together from reset, addrs 0x0010/0x0020 → gnt order m0, m1, m0, m1; rom_addr alternates 0x0010/0x0020; each rdata routed only to its owner.
- Timeout: TIMEOUT=8, ROM model never asserts en_out for an m1 read → m1_err pulses exactly 9 cycles after m1_gnt, m1_rvalid never pulses, state returns to IDLE; a following m0 read completes normally.
- Timeout/data coincidence: en_out asserted on the final WAIT cycle (TIMEOUT-1) → rvalid=1, err=0, data captured.
- Stray strobe: rom_en_out pulsed while IDLE with rom_dout=0xDEAD → no rvalid on either port, rdata unchanged.
- Reset mid-WAIT: assert rst one cycle after m0_gnt, then deliver en_out → all outputs 0, no rvalid, and after reset the first simultaneous request is granted to m0.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// Two-master round-robin arbiter in front of the shared instruction ROM.
// One outstanding ROM transaction at a time; a transaction with no response is aborted with an error pulse.
module rom_fetch_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic              m1_err,

    output logic              rom_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              rom_en_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              owner_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic              err0_q;
    logic              err1_q;

    logic              sel_valid;
    logic              sel_owner;
    logic              data_done;
    logic              timed_out;

    // Arbitration and next-state decode
    always_comb begin
        sel_valid = 1'b0;
        sel_owner = 1'b0;
        data_done = 1'b0;
        timed_out = 1'b0;
        state_d   = state_q;

        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    sel_valid = 1'b1;
                    sel_owner = ~last_grant_q;
                end else if (m0_req) begin
                    sel_valid = 1'b1;
                    sel_owner = 1'b0;
                end else if (m1_req) begin
                    sel_valid = 1'b1;
                    sel_owner = 1'b1;
                end
                if (sel_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A response on the last permitted cycle takes priority over the abort.
                data_done = rom_en_out;
                timed_out = !rom_en_out && (cnt_q == CNT_LAST);
                if (data_done || timed_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rom_addr_q   <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;

            if (sel_valid) begin
                owner_q    <= sel_owner;
                rom_addr_q <= sel_owner ? m1_addr : m0_addr;
            end

            if (state_q == ISSUE) begin
                last_grant_q <= owner_q;
                cnt_q        <= '0;
            end

            if (data_done) begin
                if (owner_q) begin
                    rdata1_q  <= rom_dout;
                    rvalid1_q <= 1'b1;
                end else begin
                    rdata0_q  <= rom_dout;
                    rvalid0_q <= 1'b1;
                end
            end else if (timed_out) begin
                err0_q <= ~owner_q;
                err1_q <= owner_q;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rom_ready = (state_q == ISSUE);
    assign rom_addr  = rom_addr_q;
    assign m0_gnt    = (state_q == ISSUE) && !owner_q;
    assign m1_gnt    = (state_q == ISSUE) && owner_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Scoreboard bench for rom_fetch_arbiter: stimulus queues expected gnt/rvalid/err events with their cycle,
// a negedge monitor pops and compares them; a behavioural ROM answers each rom_ready after rom_delay cycles.
module tb_rom_fetch_arbiter;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_gnt, m0_rvalid, m0_err;
    logic              m1_gnt, m1_rvalid, m1_err;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              rom_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              rom_en_out;

    rom_fetch_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_err    (m1_err),
        .rom_ready (rom_ready),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .rom_en_out(rom_en_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;   // 0 gnt, 1 rvalid, 2 err
        int m;
        int val;
        int cyc;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int m, input int val, input int c);
        exp_t e;
        e.kind = kind; e.m = m; e.val = val; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check(name, {m0_gnt, m0_rdata, m0_rvalid, m0_err, m1_gnt, m1_rdata, m1_rvalid, m1_err,
                     rom_ready, rom_addr}, '0);
    endtask

    function automatic logic [DATA_W-1:0] rom_lookup(input logic [ADDR_W-1:0] a);
        case (a)
            16'h0004: return 16'h1234;
            16'h0010: return 16'h1111;
            16'h0020: return 16'h2222;
            default:  return {a[7:0], 8'h5A};
        endcase
    endfunction

    // Behavioural ROM
    int              rom_delay = 1;
    bit              rom_never = 1'b0;
    bit              stray_req = 1'b0;
    int              rom_cnt   = 0;
    bit              stray_pend = 1'b0;
    logic [DATA_W-1:0] rom_data;

    initial begin
        rom_en_out = 1'b0;
        rom_dout   = '0;
        forever begin
            @(negedge clk);
            if (rom_ready && !rom_never) begin
                rom_cnt  = rom_delay;
                rom_data = rom_lookup(rom_addr);
            end
            if (stray_req) stray_pend = 1'b1;
            @(posedge clk);
            #1;
            rom_en_out = 1'b0;
            if (stray_pend) begin
                stray_pend = 1'b0;
                rom_en_out = 1'b1;
                rom_dout   = 16'hDEAD;
            end else if (rom_cnt > 0) begin
                rom_cnt--;
                if (rom_cnt == 0) begin
                    rom_en_out = 1'b1;
                    rom_dout   = rom_data;
                end
            end
        end
    end

    // Monitor / scoreboard
    logic [DATA_W-1:0] mrd0, mrd1;
    int   mk, mm, mv, nev;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            mrd0 = '0;
            mrd1 = '0;
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            me = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_event: kind %0d master %0d expected at cycle %0d, got none (now %0d)",
                     me.kind, me.m, me.cyc, cyc);
        end
        nev = int'(m0_gnt) + int'(m1_gnt) + int'(m0_rvalid) + int'(m1_rvalid) + int'(m0_err) + int'(m1_err);
        if (nev > 1) check("multi_event", 64'(nev), 64'd1);
        mk = -1; mm = 0; mv = 0;
        if (m0_gnt)         begin mk = 0; mm = 0; mv = int'(rom_addr); end
        else if (m1_gnt)    begin mk = 0; mm = 1; mv = int'(rom_addr); end
        else if (m0_rvalid) begin mk = 1; mm = 0; mv = int'(m0_rdata); end
        else if (m1_rvalid) begin mk = 1; mm = 1; mv = int'(m1_rdata); end
        else if (m0_err)    begin mk = 2; mm = 0; mv = int'(m0_rdata); end
        else if (m1_err)    begin mk = 2; mm = 1; mv = int'(m1_rdata); end
        if (mk >= 0) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: kind %0d master %0d value 0x%0h at cycle %0d, expected none",
                         mk, mm, mv, cyc);
            end else begin
                me = q.pop_front();
                if (me.kind != mk || me.m != mm || me.val != mv || me.cyc != cyc) begin
                    fails++;
                    $display("FAIL event: got kind %0d master %0d value 0x%0h cycle %0d, expected kind %0d master %0d value 0x%0h cycle %0d",
                             mk, mm, mv, cyc, me.kind, me.m, me.val, me.cyc);
                end
                if (me.kind == 1) begin
                    if (me.m == 0) mrd0 = me.val[DATA_W-1:0];
                    else           mrd1 = me.val[DATA_W-1:0];
                end
            end
            if (mk == 0) check("rom_ready_with_gnt", 64'(rom_ready), 64'd1);
            else begin
                check("m0_rdata_model", 64'(m0_rdata), 64'(mrd0));
                check("m1_rdata_model", 64'(m1_rdata), 64'(mrd1));
            end
        end
    end

    int n;

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = '0;  m1_addr = '0;
        step(2);
        check_zero("reset_outputs");
        rst = 1'b0;

        // Single m0 read
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0004;
        push(0, 0, 16'h0004, n + 1);
        push(1, 0, 16'h1234, n + 3);
        step(1);
        m0_req = 1'b0;
        step(4);
        check("t1_m1_rdata", 64'(m1_rdata), 64'h0);

        // Contention from reset: m0, m1, m0, m1
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check_zero("reset2_outputs");
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_addr = 16'h0020;
        push(0, 0, 16'h0010, n + 1);  push(1, 0, 16'h1111, n + 3);
        push(0, 1, 16'h0020, n + 4);  push(1, 1, 16'h2222, n + 6);
        push(0, 0, 16'h0010, n + 7);  push(1, 0, 16'h1111, n + 9);
        push(0, 1, 16'h0020, n + 10); push(1, 1, 16'h2222, n + 12);
        step(10);
        m0_req = 1'b0; m1_req = 1'b0;
        step(4);

        // Timeout on m1, then a normal m0 read
        rom_never = 1'b1;
        step(1);
        n = cyc;
        m1_req = 1'b1; m1_addr = 16'h0030;
        push(0, 1, 16'h0030, n + 1);
        push(2, 1, 16'h2222, n + 1 + TIMEOUT + 1);
        step(1);
        m1_req = 1'b0;
        step(TIMEOUT + 2);
        rom_never = 1'b0;
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0004;
        push(0, 0, 16'h0004, n + 1);
        push(1, 0, 16'h1234, n + 3);
        step(1);
        m0_req = 1'b0;
        step(4);

        // Response on the final WAIT cycle: data wins
        rom_delay = TIMEOUT;
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0010;
        push(0, 0, 16'h0010, n + 1);
        push(1, 0, 16'h1111, n + 2 + TIMEOUT);
        step(1);
        m0_req = 1'b0;
        step(TIMEOUT + 3);
        rom_delay = 1;

        // Stray strobe while idle
        stray_req = 1'b1;
        step(1);
        stray_req = 1'b0;
        step(4);
        check("stray_m0_rdata", 64'(m0_rdata), 64'h1111);
        check("stray_m1_rdata", 64'(m1_rdata), 64'h2222);
        check("stray_rom_ready", 64'(rom_ready), 64'h0);

        // Reset one cycle after gnt, response arrives afterwards
        rom_delay = 3;
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0004;
        push(0, 0, 16'h0004, n + 1);
        step(1);
        m0_req = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_zero("midwait_reset_outputs");
        step(3);
        check_zero("after_late_en_out");
        rom_delay = 1;
        step(1);
        n = cyc;
        m0_req = 1'b1; m0_addr = 16'h0010;
        m1_req = 1'b1; m1_addr = 16'h0020;
        push(0, 0, 16'h0010, n + 1); push(1, 0, 16'h1111, n + 3);
        push(0, 1, 16'h0020, n + 4); push(1, 1, 16'h2222, n + 6);
        step(4);
        m0_req = 1'b0; m1_req = 1'b0;
        step(4);

        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            step(1);
        end
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
